// File: rtl/writeback_buffer.sv
// Write-side front end of the register file: queues MEM/ALU results in a small FIFO, drains one
// write per cycle onto WE3/A3/WD3 and forwards still-pending writes to the operand-read side.
module writeback_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic              stall,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_mem, push_alu, pop;
    logic [PTR_W-1:0]   alu_slot;

    // Stall leaves room for a worst-case dual push, so the FIFO can never overflow.
    assign stall    = count_q > CNT_W'(DEPTH - 2);
    assign push_mem = mem_valid && !stall;
    assign push_alu = alu_valid && !stall;
    assign pop      = count_q != '0;
    assign alu_slot = wr_ptr_q + PTR_W'(push_mem);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_mem) + PTR_W'(push_alu);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is not reset; count gates every read, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (push_mem) fifo_q[wr_ptr_q] <= '{dst: mem_dst, data: mem_data};
        if (push_alu) fifo_q[alu_slot] <= '{dst: alu_dst, data: alu_data};
    end

    assign WE3 = pop;
    assign A3  = pop ? fifo_q[rd_ptr_q].dst  : '0;
    assign WD3 = pop ? fifo_q[rd_ptr_q].data : '0;

    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        // Oldest to youngest, so a later match overwrites an earlier one.
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].dst == A1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].data;
                end
                if (fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].dst == A2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: a queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_writeback_buffer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_valid = 1'b0;
    logic [ADDR_W-1:0] mem_dst = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_dst = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              stall, WE3, fwd1_hit, fwd2_hit;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3, fwd1_data, fwd2_data;
    logic [ADDR_W-1:0] A1 = '0;
    logic [ADDR_W-1:0] A2 = '0;

    writeback_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .stall(stall), .WE3(WE3), .A3(A3), .WD3(WD3),
        .A1(A1), .A2(A2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    wr_t               mq[$];
    logic [DATA_W-1:0] wr_log[$];
    bit                model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes. Inputs are stable at the falling edge, so
    // the model checks the current state there and then advances to the state after the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                logic              e_hit1, e_hit2;
                logic [DATA_W-1:0] e_d1, e_d2;
                e_hit1 = 1'b0; e_hit2 = 1'b0; e_d1 = '0; e_d2 = '0;
                foreach (mq[i]) begin
                    if (mq[i].dst == A1) begin e_hit1 = 1'b1; e_d1 = mq[i].data; end
                    if (mq[i].dst == A2) begin e_hit2 = 1'b1; e_d2 = mq[i].data; end
                end
                check("m_stall", 32'(stall), 32'((DEPTH - mq.size()) < 2));
                check("m_we3",   32'(WE3),   32'(mq.size() != 0));
                check("m_a3",    32'(A3),    mq.size() != 0 ? 32'(mq[0].dst)  : 32'd0);
                check("m_wd3",   32'(WD3),   mq.size() != 0 ? 32'(mq[0].data) : 32'd0);
                check("m_fwd1_hit",  32'(fwd1_hit),  32'(e_hit1));
                check("m_fwd1_data", 32'(fwd1_data), 32'(e_d1));
                check("m_fwd2_hit",  32'(fwd2_hit),  32'(e_hit2));
                check("m_fwd2_data", 32'(fwd2_data), 32'(e_d2));
                if (WE3 === 1'b1) wr_log.push_back(WD3);
            end
            if (rst) begin
                mq.delete();
                model_ok = 1'b1;
            end else if (model_ok) begin
                bit full_m;
                full_m = (DEPTH - mq.size()) < 2;
                if (mq.size() != 0) void'(mq.pop_front());
                if (!full_m) begin
                    if (mem_valid) mq.push_back('{dst: mem_dst, data: mem_data});
                    if (alu_valid) mq.push_back('{dst: alu_dst, data: alu_data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic offer(input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat,
                         input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat);
        mem_valid = mv; mem_dst = md; mem_data = mdat;
        alu_valid = av; alu_dst = ad; alu_data = adat;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (WE3 === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(WE3), 32'd0);
    endtask

    logic [DATA_W-1:0] exp4 [6] = '{16'h1111, 16'h4444, 16'h6666, 16'h7777, 16'h3333, 16'h5555};

    initial begin
        // 1: reset held two edges, then idle
        tick();
        tick();
        check("rst_we3", 32'(WE3), 32'd0);
        check("rst_a3", 32'(A3), 32'd0);
        check("rst_wd3", 32'(WD3), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd1", 32'(fwd1_hit), 32'd0);
        check("rst_fwd2", 32'(fwd2_hit), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_we3", 32'(WE3), 32'd0);
            check("idle_wd3", 32'(WD3), 32'd0);
        end

        // 2: single alu push
        offer(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        tick();
        idle_inputs();
        check("single_we3", 32'(WE3), 32'd1);
        check("single_a3", 32'(A3), 32'd3);
        check("single_wd3", 32'(WD3), 32'h1234);
        tick();
        check("single_we3_after", 32'(WE3), 32'd0);

        // 3: same destination from both stages
        offer(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
        tick();
        idle_inputs();
        A1 = 3'd2;
        #1;
        check("dup_wd3_first", 32'(WD3), 32'hAAAA);
        check("dup_a3_first", 32'(A3), 32'd2);
        check("dup_fwd1_hit", 32'(fwd1_hit), 32'd1);
        check("dup_fwd1_data", 32'(fwd1_data), 32'h5555);
        tick();
        check("dup_wd3_second", 32'(WD3), 32'h5555);
        tick();
        check("dup_we3_done", 32'(WE3), 32'd0);
        check("dup_fwd1_clear", 32'(fwd1_hit), 32'd0);
        A1 = 3'd0;

        // 4: back-to-back dual pushes, stall, producer retry
        wr_log.delete();
        offer(1'b1, 3'd1, 16'h1111, 1'b1, 3'd4, 16'h4444);
        tick();
        offer(1'b1, 3'd6, 16'h6666, 1'b1, 3'd7, 16'h7777);
        tick();
        offer(1'b1, 3'd3, 16'h3333, 1'b1, 3'd5, 16'h5555);
        check("full_stall", 32'(stall), 32'd1);
        begin
            int n;
            bit taken;
            n = 0;
            taken = 1'b0;
            while (!taken && n < 10) begin
                taken = (stall === 1'b0);
                tick();
                n++;
            end
            check("retry_accepted", 32'(taken), 32'd1);
        end
        idle_inputs();
        drain(10);
        check("order_count", 32'(wr_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("order_data", i < wr_log.size() ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp4[i]));

        // 5: forwarding on the second read port
        offer(1'b1, 3'd5, 16'h0F0F, 1'b0, 3'd0, 16'h0);
        tick();
        idle_inputs();
        A2 = 3'd5;
        #1;
        check("fwd2_hit", 32'(fwd2_hit), 32'd1);
        check("fwd2_data", 32'(fwd2_data), 32'h0F0F);
        A2 = 3'd6;
        #1;
        check("fwd2_miss_hit", 32'(fwd2_hit), 32'd0);
        check("fwd2_miss_data", 32'(fwd2_data), 32'd0);
        tick();
        A2 = 3'd0;

        // 6: reset with three queued writes discards them
        offer(1'b1, 3'd1, 16'hC001, 1'b1, 3'd2, 16'hC002);
        tick();
        offer(1'b1, 3'd3, 16'hC003, 1'b1, 3'd4, 16'hC004);
        tick();
        idle_inputs();
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_log.delete();
        check("mid_rst_we3", 32'(WE3), 32'd0);
        check("mid_rst_a3", 32'(A3), 32'd0);
        check("mid_rst_wd3", 32'(WD3), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_no_writes", 32'(wr_log.size()), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
